// File: rtl/alu_8bit_pkg.sv
// Shared opcode encoding and status-flag bundle for the 8-bit ALU.
// Imported by the combinational core and the registered top level.
package alu_8bit_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_SHL  = 4'b0100,
      OP_SHR  = 4'b0101,
      OP_ROL  = 4'b0110,
      OP_ROR  = 4'b0111,
      OP_AND  = 4'b1000,
      OP_OR   = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_NOR  = 4'b1011,
      OP_NAND = 4'b1100,
      OP_XNOR = 4'b1101,
      OP_GT   = 4'b1110,
      OP_EQ   = 4'b1111
   } alu_op_t;

   typedef struct packed {
      logic carry;
      logic borrow;
      logic overflow;
      logic zero;
      logic negative;
   } alu_flags_t;

endpackage

// File: rtl/alu_8bit_core.sv
// Combinational datapath: result and status flags from A, B and opcode.
// No state; the top level registers everything produced here.
module alu_8bit_core
   import alu_8bit_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] alu_sel,
   output logic [7:0] result,
   output alu_flags_t flags
);

   alu_op_t     op;
   logic [8:0]  sum;
   logic [7:0]  diff;
   logic [15:0] prod;

   assign op   = alu_op_t'(alu_sel);
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = a - b;
   assign prod = 16'(a) * 16'(b);

   always_comb begin
      result         = 8'h00;
      flags.carry    = 1'b0;
      flags.borrow   = 1'b0;
      flags.overflow = 1'b0;
      unique case (op)
         OP_ADD: begin
            result         = sum[7:0];
            flags.carry    = sum[8];
            flags.overflow = (a[7] == b[7]) && (sum[7] != a[7]);
         end
         OP_SUB: begin
            result         = diff;
            flags.borrow   = (a < b);
            flags.overflow = (a[7] != b[7]) && (diff[7] != a[7]);
         end
         OP_MUL: begin
            result      = prod[7:0];
            flags.carry = |prod[15:8];
         end
         OP_DIV: begin
            // Divide-by-zero saturates and is reported via OVERFLOW
            if (b == 8'h00) begin
               result         = 8'hFF;
               flags.overflow = 1'b1;
            end else begin
               result = a / b;
            end
         end
         OP_SHL: begin
            result      = {a[6:0], 1'b0};
            flags.carry = a[7];
         end
         OP_SHR: begin
            result      = {1'b0, a[7:1]};
            flags.carry = a[0];
         end
         OP_ROL:  result = {a[6:0], a[7]};
         OP_ROR:  result = {a[0], a[7:1]};
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_NAND: result = ~(a & b);
         OP_XNOR: result = ~(a ^ b);
         OP_GT:   result = {7'b0, (a > b)};
         OP_EQ:   result = {7'b0, (a == b)};
         default: result = 8'h00;
      endcase
      flags.zero     = (result == 8'h00);
      flags.negative = result[7];
   end

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: captures one operation per in_valid edge,
// result and flags appear one cycle later with out_valid.
module alu_8bit
   import alu_8bit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [3:0] ALU_Sel,
   input  logic       in_valid,
   output logic [7:0] ALU_Out,
   output logic       CARRY,
   output logic       BORROW,
   output logic       OVERFLOW,
   output logic       ZERO,
   output logic       NEGATIVE,
   output logic       out_valid
);

   logic [7:0] core_result;
   alu_flags_t core_flags;

   logic [7:0] alu_out_d, alu_out_q;
   alu_flags_t flags_d, flags_q;
   logic       out_valid_d, out_valid_q;

   alu_8bit_core u_core (
      .a       (A),
      .b       (B),
      .alu_sel (ALU_Sel),
      .result  (core_result),
      .flags   (core_flags)
   );

   always_comb begin
      alu_out_d   = alu_out_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         alu_out_d   = core_result;
         flags_d     = core_flags;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q   <= 8'h00;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         alu_out_q   <= alu_out_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ALU_Out   = alu_out_q;
   assign CARRY     = flags_q.carry;
   assign BORROW    = flags_q.borrow;
   assign OVERFLOW  = flags_q.overflow;
   assign ZERO      = flags_q.zero;
   assign NEGATIVE  = flags_q.negative;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: opcode sweep, flag corner cases,
// hold behaviour and asynchronous reset.
module tb_alu_8bit;

   logic       clk;
   logic       rst_n;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] ALU_Sel;
   logic       in_valid;
   logic [7:0] ALU_Out;
   logic       CARRY, BORROW, OVERFLOW, ZERO, NEGATIVE;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   logic [7:0] sweep_exp [16] = '{
      8'h0D, 8'h07, 8'h1E, 8'h03, 8'h14, 8'h05, 8'h14, 8'h05,
      8'h02, 8'h0B, 8'h09, 8'hF4, 8'hFD, 8'hF6, 8'h01, 8'h00
   };

   alu_8bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .ALU_Sel   (ALU_Sel),
      .in_valid  (in_valid),
      .ALU_Out   (ALU_Out),
      .CARRY     (CARRY),
      .BORROW    (BORROW),
      .OVERFLOW  (OVERFLOW),
      .ZERO      (ZERO),
      .NEGATIVE  (NEGATIVE),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags packed as {CARRY,BORROW,OVERFLOW,ZERO,NEGATIVE}
   task automatic chk(input string tag, input logic [7:0] res_e,
                      input logic [4:0] flg_e, input logic vld_e);
      logic [4:0] flg;
      flg = {CARRY, BORROW, OVERFLOW, ZERO, NEGATIVE};
      checks++;
      assert (ALU_Out === res_e) else begin
         errors++;
         $error("FAIL %s out: got %h want %h", tag, ALU_Out, res_e);
      end
      checks++;
      assert (flg === flg_e) else begin
         errors++;
         $error("FAIL %s flags CBOZN: got %b want %b", tag, flg, flg_e);
      end
      checks++;
      assert (out_valid === vld_e) else begin
         errors++;
         $error("FAIL %s out_valid: got %b want %b", tag, out_valid, vld_e);
      end
   endtask

   task automatic op(input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] sel);
      A        = a;
      B        = b;
      ALU_Sel  = sel;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      A        = 8'h00;
      B        = 8'h00;
      ALU_Sel  = 4'h0;
      in_valid = 1'b0;
      #2;
      chk("reset", 8'h00, 5'b00000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         logic [4:0] fe;
         fe = 5'b00000;
         if (i == 11 || i == 12 || i == 13) fe = 5'b00001;
         if (i == 15) fe = 5'b00010;
         op(8'h0A, 8'h03, 4'(i));
         chk($sformatf("sweep_%0h", i), sweep_exp[i], fe, 1'b1);
      end

      op(8'hFF, 8'h01, 4'h0);
      chk("add_ff_01", 8'h00, 5'b10010, 1'b1);
      op(8'h7F, 8'h01, 4'h0);
      chk("add_7f_01", 8'h80, 5'b00101, 1'b1);
      op(8'h00, 8'h01, 4'h1);
      chk("sub_00_01", 8'hFF, 5'b01001, 1'b1);
      op(8'h80, 8'h01, 4'h1);
      chk("sub_80_01", 8'h7F, 5'b00100, 1'b1);
      op(8'h10, 8'h00, 4'h3);
      chk("div_by_0", 8'hFF, 5'b00101, 1'b1);
      op(8'h10, 8'h10, 4'h2);
      chk("mul_10_10", 8'h00, 5'b10010, 1'b1);
      op(8'h81, 8'h00, 4'h4);
      chk("shl_81", 8'h02, 5'b10000, 1'b1);
      op(8'h81, 8'h00, 4'h5);
      chk("shr_81", 8'h40, 5'b10000, 1'b1);
      op(8'h81, 8'h00, 4'h6);
      chk("rol_81", 8'h03, 5'b00000, 1'b1);
      op(8'h81, 8'h00, 4'h7);
      chk("ror_81", 8'hC0, 5'b00001, 1'b1);
      op(8'h5A, 8'h5A, 4'hF);
      chk("eq_5a", 8'h01, 5'b00000, 1'b1);

      // idle edges hold the last result with out_valid low
      in_valid = 1'b0;
      A        = 8'hFF;
      ALU_Sel  = 4'h0;
      @(posedge clk);
      #1;
      chk("hold_1", 8'h01, 5'b00000, 1'b0);
      @(posedge clk);
      #1;
      chk("hold_2", 8'h01, 5'b00000, 1'b0);

      op(8'h0A, 8'h03, 4'h0);
      chk("pre_rst", 8'h0D, 5'b00000, 1'b1);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("async_rst", 8'h00, 5'b00000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst_idle_%0d", i), 8'h00, 5'b00000, 1'b0);
      end

      op(8'h0A, 8'h03, 4'h1);
      chk("first_after_rst", 8'h07, 5'b00000, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 The block SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have ports: A  in  8  operand A; B  in  8  operand B; ALU_Sel  in  4  opcode; in_valid  in  1  capture operands this edge.
REQ-003 The block SHALL have ports: ALU_Out  out  8  result; CARRY, BORROW, OVERFLOW, ZERO, NEGATIVE  out  1 each  status flags; out_valid  out  1  result/flags updated last edge.

Function
REQ-004 On a rising clk edge with in_valid=1, ALU_Out and all flags SHALL register the result of A, B and ALU_Sel sampled at that edge (latency 1 cycle), and out_valid SHALL be 1 for the following cycle.
REQ-005 On an edge with in_valid=0, ALU_Out and flags SHALL hold their values and out_valid SHALL be 0; back-to-back in_valid=1 SHALL give one result per cycle.
REQ-006 Opcodes SHALL be: 0000 ADD A+B; 0001 SUB A-B; 0010 MUL low 8 bits of A*B; 0011 DIV unsigned A/B; 0100 SHL A<<1; 0101 SHR logical A>>1; 0110 ROL by 1; 0111 ROR by 1.
REQ-007 Opcodes SHALL be: 1000 AND; 1001 OR; 1010 XOR; 1011 NOR; 1100 NAND; 1101 XNOR; 1110 GT (01 if A>B unsigned else 00); 1111 EQ (01 if A==B else 00).
REQ-008 All arithmetic SHALL be unsigned 8-bit with wrap-around modulo 256, except OVERFLOW, which SHALL use two's-complement interpretation.
REQ-009 CARRY SHALL be: ADD carry-out of bit 7; MUL 1 if the 16-bit product >255; SHL the old A[7]; SHR the old A[0]; 0 for all other opcodes.
REQ-010 BORROW SHALL be 1 only for SUB when A<B unsigned, else 0.
REQ-011 OVERFLOW SHALL be: ADD signed overflow (equal operand signs, result sign differs); SUB signed overflow (operand signs differ, result sign differs from A); DIV 1 when B=0; 0 otherwise.
REQ-012 DIV with B=0 SHALL produce ALU_Out=FF.
REQ-013 ZERO SHALL be 1 when the registered ALU_Out is 00, and NEGATIVE SHALL equal the registered ALU_Out[7], for every opcode.
REQ-014 Flags and ALU_Out SHALL always update together from the same capture edge; no output SHALL change between capture edges.

Reset
REQ-015 While rst_n=0, ALU_Out SHALL be 00 and CARRY, BORROW, OVERFLOW, ZERO, NEGATIVE and out_valid SHALL all be 0, taking effect immediately and independent of clk.
REQ-016 Reset asserted mid-operation SHALL discard any captured result.
REQ-017 After rst_n deasserts, the first in_valid=1 edge SHALL produce a normal result one cycle later.

Structure
REQ-018 A shared package alu_8bit_pkg SHALL hold the 16 opcode constants and the 4-bit opcode type.
REQ-019 A combinational sub-module alu_8bit_core SHALL compute the result and the five flags from A, B and ALU_Sel.
REQ-020 The top level SHALL contain only the output and out_valid registers.

Verification
REQ-021 With A=0A, B=03, sweep ALU_Sel 0..F with in_valid=1 and check each result one cycle later -> 0D,07,1E,03,14,05,14,05,02,0B,09,F4,FD,F6,01,00.
REQ-022 In the same sweep, flags SHALL be: NEGATIVE=1 for NOR, NAND and XNOR; ZERO=1 for EQ; all other flags 0.
REQ-023 ADD FF+01 -> 00 with CARRY=1, ZERO=1, OVERFLOW=0; ADD 7F+01 -> 80 with OVERFLOW=1, NEGATIVE=1.
REQ-024 SUB 00-01 -> FF with BORROW=1, NEGATIVE=1; SUB 80-01 -> 7F with OVERFLOW=1.
REQ-025 DIV 10/00 -> FF with OVERFLOW=1; MUL 10*10 -> 00 with CARRY=1, ZERO=1.
REQ-026 Assert rst_n=0 between clock edges while out_valid=1 -> all outputs 0 immediately; then in_valid=0 for 3 cycles -> outputs held at 0 and out_valid=0.
